// File: rtl/rc_servo_pkg.sv
// Shared definitions for the RC servo pulse cores (generator and decoder).
// Holds the measurement FSM state type, default tick constants and the
// position/counter widths so both cores agree on frame timing.
package rc_servo_pkg;

    localparam int unsigned POS_W = 8;   // position width, 0..250
    localparam int unsigned CNT_W = 13;  // tick counter width, covers 6250

    // Defaults assume a 10 MHz clock and a 4 us tick.
    localparam int unsigned DEF_CLKS_PER_TICK = 40;
    localparam int unsigned DEF_MIN_TICKS     = 250;   // 1000 us -> position 0
    localparam int unsigned DEF_MAX_TICKS     = 500;   // 2000 us -> position 250
    localparam int unsigned DEF_REJ_MIN_TICKS = 200;   // 800 us
    localparam int unsigned DEF_REJ_MAX_TICKS = 550;   // 2200 us
    localparam int unsigned DEF_TIMEOUT_TICKS = 6250;  // 25 ms

    typedef enum logic [1:0] {
        StWaitLow = 2'd0,
        StLow     = 2'd1,
        StHigh    = 2'd2
    } meas_state_e;

endpackage

// File: rtl/rc_servo_pwm_rx_xy_if.sv
// Per-axis servo channel bundle: the raw pad pulse going in and the decoded
// position, valid flag and update strobe coming out.
//   master : the measuring channel (reads pwm, drives pos/valid/update)
//   slave  : the pulse source / consumer (drives pwm, reads the results)
interface rc_servo_pwm_rx_xy_if;
    import rc_servo_pkg::*;

    logic             pwm;
    logic [POS_W-1:0] pos;
    logic             valid;
    logic             update;

    modport master (input pwm, output pos, output valid, output update);
    modport slave  (output pwm, input pos, input valid, input update);

endinterface

// File: rtl/rc_servo_pulse_meas.sv
// One servo channel: 2-flop synchronizer, edge detect, pulse-width FSM,
// width and timeout counters, and the registered position/valid/update.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   ena_i            : low forces the channel idle (valid/update cleared)
//   tick_i           : shared measurement tick from the top-level prescaler
//   ch               : channel bundle (pad pulse in, decoded results out)
module rc_servo_pulse_meas
    import rc_servo_pkg::*;
#(
    parameter int unsigned MIN_TICKS     = DEF_MIN_TICKS,
    parameter int unsigned MAX_TICKS     = DEF_MAX_TICKS,
    parameter int unsigned REJ_MIN_TICKS = DEF_REJ_MIN_TICKS,
    parameter int unsigned REJ_MAX_TICKS = DEF_REJ_MAX_TICKS,
    parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 ena_i,
    input  logic                 tick_i,
    rc_servo_pwm_rx_xy_if.master ch
);

    localparam logic [CNT_W-1:0] MinC     = CNT_W'(MIN_TICKS);
    localparam logic [CNT_W-1:0] MaxC     = CNT_W'(MAX_TICKS);
    localparam logic [CNT_W-1:0] RejMinC  = CNT_W'(REJ_MIN_TICKS);
    localparam logic [CNT_W-1:0] RejMaxC  = CNT_W'(REJ_MAX_TICKS);
    localparam logic [CNT_W-1:0] WidthSat = CNT_W'(REJ_MAX_TICKS + 1);
    localparam logic [CNT_W-1:0] TmoC     = CNT_W'(TIMEOUT_TICKS);

    logic sync1_q, sync2_q, sync3_q;
    // Shifts a 1 in behind reset so WAIT_LOW ignores the reset value of the
    // synchronizer and only trusts a low level that came from the pad.
    logic sv1_q, sv2_q;

    meas_state_e      state_q, state_d;
    logic [CNT_W-1:0] width_q, width_d, width_inc;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] w_clamp;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             valid_q, valid_d;
    logic             upd_q, upd_d;
    logic             rise, fall, accept;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            sv1_q   <= 1'b0;
            sv2_q   <= 1'b0;
        end else begin
            sync1_q <= ch.pwm;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            sv1_q   <= 1'b1;
            sv2_q   <= sv1_q;
        end
    end

    assign rise = sync2_q & ~sync3_q;
    assign fall = ~sync2_q & sync3_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StWaitLow;
            width_q <= '0;
            tmo_q   <= '0;
            pos_q   <= '0;
            valid_q <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            tmo_q   <= tmo_d;
            pos_q   <= pos_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        width_d = width_q;
        tmo_d   = tmo_q;
        pos_d   = pos_q;
        valid_d = valid_q;
        upd_d   = 1'b0;
        accept  = 1'b0;

        // Tick in the fall cycle is counted before the width is evaluated.
        width_inc = (tick_i && (width_q < WidthSat)) ? width_q + CNT_W'(1) : width_q;

        if (tick_i && (tmo_q < TmoC)) begin
            tmo_d = tmo_q + CNT_W'(1);
        end

        unique case (state_q)
            StWaitLow: begin
                if (sv2_q && !sync2_q) begin
                    state_d = StLow;
                end
            end
            StLow: begin
                if (rise) begin
                    width_d = '0;
                    state_d = StHigh;
                end
            end
            StHigh: begin
                width_d = width_inc;
                if (fall) begin
                    state_d = StLow;
                    accept  = (width_inc >= RejMinC) && (width_inc <= RejMaxC);
                end else if (width_q > RejMaxC) begin
                    state_d = StWaitLow;
                end
            end
            default: state_d = StWaitLow;
        endcase

        if (width_inc < MinC) begin
            w_clamp = MinC;
        end else if (width_inc > MaxC) begin
            w_clamp = MaxC;
        end else begin
            w_clamp = width_inc;
        end

        if (accept) begin
            pos_d   = POS_W'(w_clamp - MinC);
            valid_d = 1'b1;
            upd_d   = 1'b1;
            tmo_d   = '0;
        end else if (tmo_d == TmoC) begin
            valid_d = 1'b0;
        end

        if (!ena_i) begin
            state_d = StWaitLow;
            valid_d = 1'b0;
            upd_d   = 1'b0;
            tmo_d   = '0;
            pos_d   = pos_q;
        end
    end

    assign ch.pos    = pos_q;
    assign ch.valid  = valid_q;
    assign ch.update = upd_q;

endmodule

// File: rtl/rc_servo_pwm_rx_xy.sv
// Two-channel RC servo pulse decoder (X and Y). Measures servo pulse high
// time on asynchronous pads and reports an 8-bit position per axis.
// Ports:
//   clk_i, reset_n_i       : clock, asynchronous active-low reset
//   ena_i                  : decoder enable, low holds both channels idle
//   pwm_x_i, pwm_y_i       : asynchronous servo pulse inputs
//   pos_x_o, pos_y_o       : decoded positions 0..250
//   valid_x_o, valid_y_o   : accepted pulse seen within the timeout window
//   update_x_o, update_y_o : one-cycle strobe when the position is rewritten
module rc_servo_pwm_rx_xy
    import rc_servo_pkg::*;
#(
    parameter int unsigned CLKS_PER_TICK = DEF_CLKS_PER_TICK,
    parameter int unsigned MIN_TICKS     = DEF_MIN_TICKS,
    parameter int unsigned MAX_TICKS     = DEF_MAX_TICKS,
    parameter int unsigned REJ_MIN_TICKS = DEF_REJ_MIN_TICKS,
    parameter int unsigned REJ_MAX_TICKS = DEF_REJ_MAX_TICKS,
    parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             ena_i,
    input  logic             pwm_x_i,
    input  logic             pwm_y_i,
    output logic [POS_W-1:0] pos_x_o,
    output logic [POS_W-1:0] pos_y_o,
    output logic             valid_x_o,
    output logic             valid_y_o,
    output logic             update_x_o,
    output logic             update_y_o
);

    localparam int unsigned PreW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;

    logic [PreW-1:0] pre_q, pre_d;
    logic            tick, tick_gated;

    assign tick = (pre_q == PreW'(CLKS_PER_TICK - 1));

    always_comb begin
        pre_d = tick ? '0 : pre_q + PreW'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // Prescaler keeps running while disabled; only the channels see the gate.
    assign tick_gated = tick & ena_i;

    rc_servo_pwm_rx_xy_if x_ch ();
    rc_servo_pwm_rx_xy_if y_ch ();

    assign x_ch.pwm   = pwm_x_i;
    assign y_ch.pwm   = pwm_y_i;
    assign pos_x_o    = x_ch.pos;
    assign pos_y_o    = y_ch.pos;
    assign valid_x_o  = x_ch.valid;
    assign valid_y_o  = y_ch.valid;
    assign update_x_o = x_ch.update;
    assign update_y_o = y_ch.update;

    rc_servo_pulse_meas #(
        .MIN_TICKS     (MIN_TICKS),
        .MAX_TICKS     (MAX_TICKS),
        .REJ_MIN_TICKS (REJ_MIN_TICKS),
        .REJ_MAX_TICKS (REJ_MAX_TICKS),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_meas_x (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .ena_i     (ena_i),
        .tick_i    (tick_gated),
        .ch        (x_ch)
    );

    rc_servo_pulse_meas #(
        .MIN_TICKS     (MIN_TICKS),
        .MAX_TICKS     (MAX_TICKS),
        .REJ_MIN_TICKS (REJ_MIN_TICKS),
        .REJ_MAX_TICKS (REJ_MAX_TICKS),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_meas_y (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .ena_i     (ena_i),
        .tick_i    (tick_gated),
        .ch        (y_ch)
    );

endmodule
